// File: rtl/hatch_ctrl_pkg.sv
// Shared definitions for the egg-hatching sequencer: FSM state codes,
// stage-code width and a helper that sizes saturating counters.
package hatch_ctrl_pkg;

  // Width of the stage code sent to the dot-matrix transfer block
  localparam int DZ_W = 5;

  // Game states; the numeric codes are also shown on the tube display
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INCUB = 2'd1,
    ST_HATCH = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  // Bits needed to hold 0..limit; never less than one bit
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/hatch_ctrl_if.sv
// Bundle of game-control signals between the switch/tick front end
// (master) and the hatch sequencer (slave).
interface hatch_ctrl_if;
  import hatch_ctrl_pkg::*;

  logic            tick;
  logic            start;
  logic            heat;
  logic [DZ_W-1:0] dz_num;
  logic            fail;
  logic            hatched;
  logic            dz_upd;
  logic [1:0]      state;

  modport master (
    output tick, start, heat,
    input  dz_num, fail, hatched, dz_upd, state
  );

  modport slave (
    input  tick, start, heat,
    output dz_num, fail, hatched, dz_upd, state
  );

endinterface

// File: rtl/hatch_ctrl_sat_cnt.sv
// Saturating up-counter: counts on inc, sticks at LIMIT, clr has priority.
module hatch_ctrl_sat_cnt #(
  parameter int WIDTH = 1,
  parameter int LIMIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  // Count register: clear first, otherwise increment until the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != LIM)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count    = r_count;
  assign at_limit = (r_count == LIM);

endmodule

// File: rtl/hatch_ctrl.sv
// Egg-hatching game sequencer: times incubation from the 1 Hz tick and the
// heat switch, and produces the stage code, fail/hatched flags and an
// update strobe for the dot-matrix blocks.
module hatch_ctrl
  import hatch_ctrl_pkg::*;
#(
  parameter int STAGE_TICKS = 4,
  parameter int STAGES      = 16,
  parameter int COLD_LIMIT  = 3,
  parameter int HOT_LIMIT   = 10
) (
  input  logic  clk,
  input  logic  rst,
  hatch_ctrl_if.slave bus
);

  localparam int HOT_W  = cnt_w(HOT_LIMIT);
  localparam int COLD_W = cnt_w(COLD_LIMIT);
  localparam int STG_W  = cnt_w(STAGE_TICKS - 1);

  // Counter value one short of the kill limit: the next tick of that kind kills
  localparam logic [HOT_W-1:0]  HOT_LAST  = HOT_W'(HOT_LIMIT - 1);
  localparam logic [COLD_W-1:0] COLD_LAST = COLD_W'(COLD_LIMIT - 1);
  localparam logic [DZ_W-1:0]   STAGES_C  = DZ_W'(STAGES);

  state_t          r_state;
  logic [DZ_W-1:0] r_dz_num;
  logic            r_fail;
  logic            r_hatched;
  logic            r_dz_upd;

  state_t          w_state_next;
  logic [DZ_W-1:0] w_dz_next;
  logic            w_fail_next;
  logic            w_hatched_next;
  logic            w_upd_next;

  logic              w_hot_inc, w_hot_clr, w_hot_max;
  logic              w_cold_inc, w_cold_clr, w_cold_max;
  logic              w_stage_inc, w_stage_clr, w_stage_wrap;
  logic [HOT_W-1:0]  w_hot_cnt;
  logic [COLD_W-1:0] w_cold_cnt;
  logic [STG_W-1:0]  w_stage_cnt;
  logic [DZ_W-1:0]   w_dz_inc;
  logic              w_hot_kill, w_cold_kill;

  hatch_ctrl_sat_cnt #(.WIDTH(HOT_W), .LIMIT(HOT_LIMIT)) u_hot_cnt (
    .clk(clk), .rst(rst), .inc(w_hot_inc), .clr(w_hot_clr),
    .count(w_hot_cnt), .at_limit(w_hot_max)
  );

  hatch_ctrl_sat_cnt #(.WIDTH(COLD_W), .LIMIT(COLD_LIMIT)) u_cold_cnt (
    .clk(clk), .rst(rst), .inc(w_cold_inc), .clr(w_cold_clr),
    .count(w_cold_cnt), .at_limit(w_cold_max)
  );

  // Stage-tick counter tops out at STAGE_TICKS-1; a warm tick there wraps it via clr
  hatch_ctrl_sat_cnt #(.WIDTH(STG_W), .LIMIT(STAGE_TICKS - 1)) u_stage_cnt (
    .clk(clk), .rst(rst), .inc(w_stage_inc), .clr(w_stage_clr),
    .count(w_stage_cnt), .at_limit(w_stage_wrap)
  );

  assign w_dz_inc    = r_dz_num + 1'b1;
  // A saturated counter also counts as a kill so the egg can never outlive it
  assign w_hot_kill  = (w_hot_cnt == HOT_LAST) || w_hot_max;
  assign w_cold_kill = (w_cold_cnt == COLD_LAST) || w_cold_max;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_dz_num  <= '0;
      r_fail    <= 1'b0;
      r_hatched <= 1'b0;
      r_dz_upd  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_dz_num  <= w_dz_next;
      r_fail    <= w_fail_next;
      r_hatched <= w_hatched_next;
      r_dz_upd  <= w_upd_next;
    end
  end

  // Next-state, next-output and counter control
  always_comb begin
    w_state_next   = r_state;
    w_dz_next      = r_dz_num;
    w_fail_next    = r_fail;
    w_hatched_next = r_hatched;
    w_upd_next     = 1'b0;
    w_hot_inc      = 1'b0;
    w_hot_clr      = 1'b0;
    w_cold_inc     = 1'b0;
    w_cold_clr     = 1'b0;
    w_stage_inc    = 1'b0;
    w_stage_clr    = 1'b0;

    case (r_state)
      ST_INCUB: begin
        // start is ignored mid-game; only ticks move the game on
        if (bus.tick) begin
          if (bus.heat) begin
            w_cold_clr  = 1'b1;
            w_hot_inc   = 1'b1;
            w_stage_clr = w_stage_wrap;
            w_stage_inc = !w_stage_wrap;
            if (w_hot_kill) begin
              // Overheating beats a coincident stage step: stage code frozen
              w_state_next = ST_FAIL;
              w_fail_next  = 1'b1;
              w_upd_next   = 1'b1;
            end else if (w_stage_wrap) begin
              w_dz_next  = w_dz_inc;
              w_upd_next = 1'b1;
              if (w_dz_inc == STAGES_C) begin
                w_state_next   = ST_HATCH;
                w_hatched_next = 1'b1;
              end
            end
          end else begin
            w_hot_clr  = 1'b1;
            w_cold_inc = 1'b1;
            if (w_cold_kill) begin
              w_state_next = ST_FAIL;
              w_fail_next  = 1'b1;
              w_upd_next   = 1'b1;
            end
          end
        end
      end
      default: begin
        // IDLE, HATCH, FAIL: start (re)begins a game, any tick is dropped
        if (bus.start) begin
          w_state_next   = ST_INCUB;
          w_dz_next      = '0;
          w_fail_next    = 1'b0;
          w_hatched_next = 1'b0;
          w_upd_next     = 1'b1;
          w_hot_clr      = 1'b1;
          w_cold_clr     = 1'b1;
          w_stage_clr    = 1'b1;
        end
      end
    endcase
  end

  assign bus.dz_num  = r_dz_num;
  assign bus.fail    = r_fail;
  assign bus.hatched = r_hatched;
  assign bus.dz_upd  = r_dz_upd;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_hatch_ctrl.sv
// Self-checking bench for hatch_ctrl: constant vector table, hand sequences
// for multi-cycle corners, and randomized play against a behavioural model.
module tb_hatch_ctrl;

  localparam int ST = 4;
  localparam int NS = 16;
  localparam int CL = 3;
  localparam int HL = 10;

  localparam int M_IDLE  = 0;
  localparam int M_INCUB = 1;
  localparam int M_HATCH = 2;
  localparam int M_FAIL  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hatch_ctrl_if bus1 ();
  hatch_ctrl_if bus2 ();

  hatch_ctrl #(.STAGE_TICKS(ST), .STAGES(NS), .COLD_LIMIT(CL), .HOT_LIMIT(HL)) dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  hatch_ctrl #(.STAGE_TICKS(1), .STAGES(16), .COLD_LIMIT(3), .HOT_LIMIT(16)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: game described by runs of warm/cold ticks and the
  // total of warm ticks; the stage is total warm ticks divided by STAGE_TICKS.
  int m_mode, m_wrun, m_crun, m_wtot, m_dz, m_fail, m_hatched, m_upd;

  typedef struct {
    bit t, s, h;
    int dz, f, hc, u, st;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_wrun = 0; m_crun = 0; m_wtot = 0;
    m_dz = 0; m_fail = 0; m_hatched = 0; m_upd = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit h);
    m_upd = 0;
    if (s && m_mode != M_INCUB) begin
      m_mode = M_INCUB; m_wrun = 0; m_crun = 0; m_wtot = 0;
      m_dz = 0; m_fail = 0; m_hatched = 0; m_upd = 1;
    end else if (t && m_mode == M_INCUB) begin
      if (h) begin
        m_wrun++; m_crun = 0;
        if (m_wrun >= HL) begin
          m_mode = M_FAIL; m_fail = 1; m_upd = 1;
        end else begin
          m_wtot++;
          if (m_wtot / ST != m_dz) begin
            m_dz = m_wtot / ST; m_upd = 1;
            if (m_dz >= NS) begin m_mode = M_HATCH; m_hatched = 1; end
          end
        end
      end else begin
        m_crun++; m_wrun = 0;
        if (m_crun >= CL) begin m_mode = M_FAIL; m_fail = 1; m_upd = 1; end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dz_num"},  int'(bus1.dz_num),  m_dz);
    chk({tag, ".fail"},    int'(bus1.fail),    m_fail);
    chk({tag, ".hatched"}, int'(bus1.hatched), m_hatched);
    chk({tag, ".dz_upd"},  int'(bus1.dz_upd),  m_upd);
    chk({tag, ".state"},   int'(bus1.state),   m_mode);
  endtask

  // One clock on the default-parameter DUT, checked against the model
  task automatic cyc(input bit t, input bit s, input bit h, input string tag);
    bus1.tick = t; bus1.start = s; bus1.heat = h;
    @(posedge clk);
    model_step(t, s, h);
    #1;
    check_model(tag);
    bus1.tick = 1'b0; bus1.start = 1'b0;
  endtask

  task automatic cyc2(input bit t, input bit s, input bit h);
    bus2.tick = t; bus2.start = s; bus2.heat = h;
    @(posedge clk);
    #1;
    bus2.tick = 1'b0; bus2.start = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus1.tick = 1'b0; bus1.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_model(tag);
  endtask

  initial begin
    int upd_cnt, warm;
    bit t, s, h;

    rst = 1'b1;
    bus1.tick = 1'b0; bus1.start = 1'b0; bus1.heat = 1'b0;
    bus2.tick = 1'b0; bus2.start = 1'b0; bus2.heat = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    chk("reset.dut2.state", int'(bus2.state), 0);
    rst = 1'b0;

    // ---- table: {tick,start,heat} -> {dz_num,fail,hatched,dz_upd,state}
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 1};  // start from IDLE
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1};  // cold 1
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1};  // warm 1
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1, 0, 0, 1, 1};  // 4th warm -> stage 1
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 1};  // start ignored mid-game
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 1, 3};  // 3rd cold -> FAIL
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1, 1, 0, 0, 3};  // tick ignored in FAIL
    tbl[13] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 1};  // restart
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].t, tbl[i].s, tbl[i].h, $sformatf("vec%0d", i));
      $display("vec %0d: tick=%0b start=%0b heat=%0b -> dz=%0d fail=%0b hatched=%0b upd=%0b state=%0d",
               i, tbl[i].t, tbl[i].s, tbl[i].h, bus1.dz_num, bus1.fail, bus1.hatched,
               bus1.dz_upd, bus1.state);
      chk($sformatf("vec%0d.dz_num", i),  int'(bus1.dz_num),  tbl[i].dz);
      chk($sformatf("vec%0d.fail", i),    int'(bus1.fail),    tbl[i].f);
      chk($sformatf("vec%0d.hatched", i), int'(bus1.hatched), tbl[i].hc);
      chk($sformatf("vec%0d.dz_upd", i),  int'(bus1.dz_upd),  tbl[i].u);
      chk($sformatf("vec%0d.state", i),   int'(bus1.state),   tbl[i].st);
    end

    // ---- rst mid-game at dz_num=5 with a tick pending
    for (int i = 0; i < 20; i++) begin
      if (i % 8 == 7) cyc(1'b1, 1'b0, 1'b0, "to5.cold");
      cyc(1'b1, 1'b0, 1'b1, "to5.warm");
    end
    chk("mid.dz_before_rst", int'(bus1.dz_num), 5);
    rst = 1'b1; bus1.tick = 1'b1; bus1.heat = 1'b1;
    @(posedge clk); #1;
    $display("seq rst-mid: state=%0d dz=%0d fail=%0b upd=%0b", bus1.state, bus1.dz_num, bus1.fail, bus1.dz_upd);
    chk("rstmid.state",  int'(bus1.state),  0);
    chk("rstmid.dz_num", int'(bus1.dz_num), 0);
    chk("rstmid.fail",   int'(bus1.fail),   0);
    chk("rstmid.dz_upd", int'(bus1.dz_upd), 0);
    rst = 1'b0; bus1.tick = 1'b0;
    model_reset();
    cyc(1'b1, 1'b0, 1'b1, "rstmid.tick_ignored");
    chk("rstmid.after_tick.state", int'(bus1.state), 0);

    // ---- 9 warm / 1 cold until 64 warm ticks -> hatched
    cyc(1'b0, 1'b1, 1'b0, "hatch.start");
    upd_cnt = 0; warm = 0;
    while (warm < 64) begin
      for (int w = 0; w < 9 && warm < 64; w++) begin
        cyc(1'b1, 1'b0, 1'b1, "hatch.warm");
        warm++;
        if (bus1.dz_upd) upd_cnt++;
      end
      if (warm < 64) cyc(1'b1, 1'b0, 1'b0, "hatch.cold");
    end
    $display("seq hatch: dz=%0d hatched=%0b state=%0d steps=%0d", bus1.dz_num, bus1.hatched, bus1.state, upd_cnt);
    chk("hatch.steps",   upd_cnt, 16);
    chk("hatch.dz_num",  int'(bus1.dz_num), 16);
    chk("hatch.hatched", int'(bus1.hatched), 1);
    chk("hatch.state",   int'(bus1.state), 2);

    // ---- restart from HATCH, then 3 cold ticks -> FAIL with one strobe
    cyc(1'b0, 1'b1, 1'b0, "cold.start");
    chk("cold.start.hatched", int'(bus1.hatched), 0);
    upd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, "cold.tick");
      if (bus1.dz_upd) upd_cnt++;
    end
    chk("cold.fail_on_3rd", int'(bus1.fail), 1);
    cyc(1'b0, 1'b0, 1'b0, "cold.idle");
    if (bus1.dz_upd) upd_cnt++;
    $display("seq cold: fail=%0b dz=%0d state=%0d strobes=%0d", bus1.fail, bus1.dz_num, bus1.state, upd_cnt);
    chk("cold.strobes", upd_cnt, 1);
    chk("cold.dz_num",  int'(bus1.dz_num), 0);
    chk("cold.state",   int'(bus1.state), 3);

    // ---- in FAIL: start with tick -> fresh game, tick dropped
    cyc(1'b1, 1'b1, 1'b1, "restart.start_tick");
    chk("restart.state",  int'(bus1.state), 1);
    chk("restart.dz_num", int'(bus1.dz_num), 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, "restart.warm");
    chk("restart.dz_after3", int'(bus1.dz_num), 0);
    cyc(1'b1, 1'b0, 1'b1, "restart.warm4");
    $display("seq restart: dz after 4 warm ticks=%0d", bus1.dz_num);
    chk("restart.dz_after4", int'(bus1.dz_num), 1);

    // ---- 10 consecutive warm ticks -> FAIL, stage frozen at 2
    do_reset("hot.reset");
    cyc(1'b0, 1'b1, 1'b0, "hot.start");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, "hot.warm");
    chk("hot.dz_after8", int'(bus1.dz_num), 2);
    cyc(1'b1, 1'b0, 1'b1, "hot.warm9");
    chk("hot.fail_after9", int'(bus1.fail), 0);
    cyc(1'b1, 1'b0, 1'b1, "hot.warm10");
    chk("hot.fail_after10", int'(bus1.fail), 1);
    chk("hot.state", int'(bus1.state), 3);
    cyc(1'b1, 1'b0, 1'b1, "hot.warm11");
    cyc(1'b1, 1'b0, 1'b1, "hot.warm12");
    $display("seq hot: fail=%0b dz=%0d state=%0d", bus1.fail, bus1.dz_num, bus1.state);
    chk("hot.dz_frozen", int'(bus1.dz_num), 2);

    // ---- STAGE_TICKS=1, HOT_LIMIT=16: both limits on tick 16, FAIL wins
    cyc2(1'b0, 1'b1, 1'b0);
    chk("dut2.start.state", int'(bus2.state), 1);
    for (int i = 0; i < 15; i++) cyc2(1'b1, 1'b0, 1'b1);
    chk("dut2.dz_after15",   int'(bus2.dz_num), 15);
    chk("dut2.fail_after15", int'(bus2.fail), 0);
    cyc2(1'b1, 1'b0, 1'b1);
    $display("seq tie: fail=%0b hatched=%0b dz=%0d state=%0d", bus2.fail, bus2.hatched, bus2.dz_num, bus2.state);
    chk("dut2.fail",    int'(bus2.fail), 1);
    chk("dut2.hatched", int'(bus2.hatched), 0);
    chk("dut2.dz_num",  int'(bus2.dz_num), 15);
    chk("dut2.state",   int'(bus2.state), 3);

    // ---- randomized play against the model
    for (int n = 0; n < 3000; n++) begin
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 39) == 0);
      if (m_wrun < 8) h = ($urandom_range(0, 9) < 9);
      else            h = ($urandom_range(0, 9) < 3);
      if (m_mode == M_INCUB && t && s) s = 1'b0;
      if ($urandom_range(0, 599) == 0) do_reset("rand.reset");
      else                             cyc(t, s, h, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
